m_strap_ctrl: RTL and testbench

M_STRAP_CTRL -- requirements
Module: m_strap_ctrl

---
 rtl/m_strap_ctrl.sv | 127 ++++++++++++
 tb/tb_m_strap_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_strap_ctrl.sv
// rtl/m_strap_ctrl.sv - serial strap loader with shadow register, commit and abort
module m_strap_ctrl #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_din,
    input  logic             commit,
    input  logic             abort,
    output logic [WIDTH-1:0] straps,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        READY = 2'd2,
        APPLY = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shadow;
    logic [CW-1:0]    cnt;
    logic             clr_shadow;
    logic             shift_en;
    logic             set_err;

    // Next-state decode; abort beats cfg_start beats commit beats cfg_valid.
    // An illegal commit during SHIFT is flagged but does not swallow a data bit.
    always_comb begin
        state_nxt  = state;
        clr_shadow = 1'b0;
        shift_en   = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_nxt  = SHIFT;
                    clr_shadow = 1'b1;
                end else if (commit) begin
                    set_err = 1'b1;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_nxt  = IDLE;
                    clr_shadow = 1'b1;
                end else if (cfg_start) begin
                    clr_shadow = 1'b1;
                    set_err    = 1'b1;
                end else begin
                    set_err = commit;
                    if (cfg_valid) begin
                        shift_en = 1'b1;
                        if (cnt == LAST) begin
                            state_nxt = READY;
                        end
                    end
                end
            end
            READY: begin
                if (abort) begin
                    state_nxt  = IDLE;
                    clr_shadow = 1'b1;
                end else if (cfg_start) begin
                    state_nxt  = SHIFT;
                    clr_shadow = 1'b1;
                    set_err    = 1'b1;
                end else if (commit) begin
                    state_nxt = APPLY;
                end else if (cfg_valid) begin
                    set_err = 1'b1;
                end
            end
            APPLY: begin
                state_nxt = IDLE;
                set_err   = commit;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, shadow/counter, sticky error and strap output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            straps <= DEFAULT_VAL;
            shadow <= '0;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clr_shadow) begin
                shadow <= '0;
                cnt    <= '0;
            end else if (shift_en) begin
                shadow[cnt] <= cfg_din;
                if (cnt != LAST) begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (set_err) begin
                err <= 1'b1;
            end
            if (state == APPLY) begin
                straps <= shadow;
            end
        end
    end

    assign ready = (state == READY);
    assign busy  = (state != IDLE);
    assign done  = (state == APPLY);

endmodule

// File: tb/tb_m_strap_ctrl.sv
// tb/tb_m_strap_ctrl.sv - directed self-checking bench for m_strap_ctrl
`timescale 1ns/1ps
module tb_m_strap_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_start;
    logic       cfg_valid;
    logic       cfg_din;
    logic       commit;
    logic       abort;
    logic [7:0] straps;
    logic       ready;
    logic       busy;
    logic       done;
    logic       err;

    int vectors;
    int miscompares;

    m_strap_ctrl #(.WIDTH(8), .DEFAULT_VAL(8'hFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_din   (cfg_din),
        .commit    (commit),
        .abort     (abort),
        .straps    (straps),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_din = 1'b0;
        commit = 1'b0; abort = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        cfg_valid = 1'b1;
        cfg_din   = b;
        tick();
        cfg_valid = 1'b0;
        cfg_din   = 1'b0;
    endtask

    task automatic load_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (straps !== 8'hFF || ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got straps=%h ready=%b busy=%b done=%b err=%b, want ff 0 0 0 0",
                     straps, ready, busy, done, err);
        end
    endtask

    task automatic test_basic_load();
        do_reset();
        start_load();
        vectors++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_shift_entry: got busy=%b ready=%b, want 1 0", busy, ready);
        end
        for (int i = 0; i < 7; i++) send_bit(1'(8'h5A >> i));
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_ready_early: got ready=%b after 7 bits, want 0", ready);
        end
        send_bit(1'b0);
        vectors++;
        if (ready !== 1'b1 || straps !== 8'hFF) begin
            miscompares++;
            $display("FAIL basic_ready: got ready=%b straps=%h, want 1 ff", ready, straps);
        end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        vectors++;
        if (done !== 1'b1 || straps !== 8'hFF || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_apply: got done=%b straps=%h ready=%b, want 1 ff 0", done, straps, ready);
        end
        tick();
        vectors++;
        if (straps !== 8'h5A || done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_result: got straps=%h done=%b busy=%b err=%b, want 5a 0 0 0",
                     straps, done, busy, err);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] w;
        w = 8'h3C;
        do_reset();
        start_load();
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < (i % 3) + 1; g++) tick();
            if (i == 7) begin
                vectors++;
                if (ready !== 1'b0 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL gaps_hold: got ready=%b busy=%b before last bit, want 0 1", ready, busy);
                end
            end
            send_bit(w[i]);
        end
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL gaps_ready: got ready=%b, want 1", ready);
        end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        vectors++;
        if (straps !== 8'h3C || err !== 1'b0) begin
            miscompares++;
            $display("FAIL gaps_result: got straps=%h err=%b, want 3c 0", straps, err);
        end
    endtask

    task automatic test_abort();
        do_reset();
        start_load();
        load_word(8'h00);
        do_reset();
        start_load();
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b0 || ready !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: got busy=%b ready=%b done=%b, want 0 0 0", busy, ready, done);
        end
        tick();
        vectors++;
        if (straps !== 8'hFF || done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_straps: got straps=%h done=%b err=%b, want ff 0 0", straps, done, err);
        end
    endtask

    task automatic test_restart();
        do_reset();
        start_load();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        start_load();
        vectors++;
        if (err !== 1'b1 || busy !== 1'b1 || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_err: got err=%b busy=%b ready=%b, want 1 1 0", err, busy, ready);
        end
        load_word(8'h81);
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_ready: got ready=%b after 8 bits, want 1", ready);
        end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        vectors++;
        if (straps !== 8'h81 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_result: got straps=%h err=%b, want 81 1", straps, err);
        end
    endtask

    task automatic test_rst_in_ready();
        do_reset();
        start_load();
        load_word(8'h11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (straps !== 8'hFF || ready !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_ready: got straps=%h ready=%b err=%b busy=%b, want ff 0 0 0",
                     straps, ready, err, busy);
        end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        vectors++;
        if (err !== 1'b1 || straps !== 8'hFF || done !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_commit_idle: got err=%b straps=%h done=%b, want 1 ff 0", err, straps, done);
        end
    endtask

    task automatic test_err_paths();
        do_reset();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        vectors++;
        if (err !== 1'b1 || straps !== 8'hFF || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL err_commit_idle: got err=%b straps=%h busy=%b, want 1 ff 0", err, straps, busy);
        end
        do_reset();
        start_load();
        load_word(8'hA5);
        send_bit(1'b0);
        vectors++;
        if (err !== 1'b1 || ready !== 1'b1 || straps !== 8'hFF) begin
            miscompares++;
            $display("FAIL err_valid_ready: got err=%b ready=%b straps=%h, want 1 1 ff", err, ready, straps);
        end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        vectors++;
        if (straps !== 8'hA5 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_final: got straps=%h err=%b, want a5 1", straps, err);
        end
    endtask

    task automatic test_priority();
        do_reset();
        start_load();
        load_word(8'h42);
        abort = 1'b1; cfg_start = 1'b1; commit = 1'b1;
        tick();
        abort = 1'b0; cfg_start = 1'b0; commit = 1'b0;
        vectors++;
        if (busy !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_abort: got busy=%b err=%b done=%b, want 0 0 0", busy, err, done);
        end
        tick();
        vectors++;
        if (straps !== 8'hFF) begin
            miscompares++;
            $display("FAIL prio_straps: got straps=%h, want ff", straps);
        end
    endtask

    task automatic test_apply_abort();
        do_reset();
        start_load();
        load_word(8'h0F);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (straps !== 8'h0F || busy !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL apply_abort: got straps=%h busy=%b err=%b, want 0f 0 0", straps, busy, err);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        start_load();
        load_word(8'hC3);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        start_load();
        load_word(8'h3C);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        vectors++;
        if (straps !== 8'hC3 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_hold: got straps=%h done=%b, want c3 1", straps, done);
        end
        tick();
        vectors++;
        if (straps !== 8'h3C || err !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_result: got straps=%h err=%b, want 3c 0", straps, err);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_din = 1'b0;
        commit = 1'b0; abort = 1'b0;
        test_reset();
        test_basic_load();
        test_gaps();
        test_abort();
        test_restart();
        test_rst_in_ready();
        test_err_paths();
        test_priority();
        test_apply_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
